// File: rtl/keypad_code_tx.sv
// Debounces keypad switches, buffers a CODE_LEN one-hot code and replays it to the lock checker.
// Optional build macro KEYPAD_AUTO_SEND_EN: a full buffer arms the frame without an enter press.

module keypad_debounce #(
    parameter int W               = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable
);
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0] sync1, sync2, prev;
    logic [15:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
            if (sync2 != prev)
                cnt <= '0;
            else if (cnt != CNT_LAST)
                cnt <= cnt + 16'd1;
            if (sync2 == prev && cnt == CNT_LAST)
                stable <= sync2;
        end
    end
endmodule

module keypad_code_tx #(
    parameter int CODE_LEN        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sw_in,
    input  logic       enter,
    input  logic       clear,
    input  logic       rx_ready,
    output logic [9:0] sr_out,
    output logic       sr_valid,
    output logic       busy,
    output logic [2:0] digit_count,
    output logic       frame_done
);
    localparam logic [2:0]  LEN      = 3'(CODE_LEN);
    localparam logic [2:0]  LAST_IDX = 3'(CODE_LEN - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {ST_COLLECT, ST_ARM, ST_SEND, ST_GAP} state_t;

    state_t      state, state_nxt;
    logic [9:0]  code_buf [8];
    logic [9:0]  buf_nxt  [8];
    logic [2:0]  idx, idx_nxt, count_nxt;
    logic [15:0] gap_cnt, gap_nxt;
    logic [9:0]  sr_out_nxt;
    logic        sr_valid_nxt, busy_nxt, done_nxt;

    logic [9:0]  sw_stable, sw_stable_d, rise;
    logic        enter_stable, enter_stable_d, clear_stable, clear_stable_d;
    logic        enter_p, clear_p;
    logic        press_vld, wr;
    logic [9:0]  press_dat;

    keypad_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk(clk), .rst(rst), .raw(sw_in), .stable(sw_stable));
    keypad_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk(clk), .rst(rst), .raw(enter), .stable(enter_stable));
    keypad_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk(clk), .rst(rst), .raw(clear), .stable(clear_stable));

    assign rise    = sw_stable & ~sw_stable_d;
    assign enter_p = enter_stable & ~enter_stable_d;
    assign clear_p = clear_stable & ~clear_stable_d;
    assign wr      = press_vld && (digit_count < LEN);

    // Press is registered so chords (rise with more than one bit, or another key held) never store.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_stable_d    <= '0;
            enter_stable_d <= 1'b0;
            clear_stable_d <= 1'b0;
            press_vld      <= 1'b0;
            press_dat      <= '0;
        end else begin
            sw_stable_d    <= sw_stable;
            enter_stable_d <= enter_stable;
            clear_stable_d <= clear_stable;
            press_vld      <= (rise != '0) && ((rise & (rise - 10'd1)) == '0) && (sw_stable == rise);
            press_dat      <= rise;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_COLLECT;
            idx         <= '0;
            gap_cnt     <= '0;
            digit_count <= '0;
            sr_out      <= '0;
            sr_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            for (int i = 0; i < 8; i++)
                code_buf[i] <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            gap_cnt     <= gap_nxt;
            digit_count <= count_nxt;
            sr_out      <= sr_out_nxt;
            sr_valid    <= sr_valid_nxt;
            busy        <= busy_nxt;
            frame_done  <= done_nxt;
            for (int i = 0; i < 8; i++)
                code_buf[i] <= buf_nxt[i];
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        gap_nxt      = gap_cnt;
        count_nxt    = digit_count;
        sr_out_nxt   = '0;
        sr_valid_nxt = 1'b0;
        done_nxt     = 1'b0;
        for (int i = 0; i < 8; i++)
            buf_nxt[i] = code_buf[i];

        case (state)
            ST_COLLECT: begin
                if (clear_p) begin
                    count_nxt = '0;
                    for (int i = 0; i < 8; i++)
                        buf_nxt[i] = '0;
                end else begin
                    if (wr) begin
                        buf_nxt[digit_count] = press_dat;
                        count_nxt            = digit_count + 3'd1;
                    end
                    if (enter_p && count_nxt != '0)
                        state_nxt = ST_ARM;
`ifdef KEYPAD_AUTO_SEND_EN
                    if (wr && count_nxt == LEN)
                        state_nxt = ST_ARM;
`endif
                end
            end
            ST_ARM: begin
                if (rx_ready) begin
                    state_nxt    = ST_SEND;
                    idx_nxt      = '0;
                    sr_out_nxt   = code_buf[0];
                    sr_valid_nxt = 1'b1;
                end
            end
            ST_SEND: begin
                if (idx == LAST_IDX) begin
                    state_nxt = ST_GAP;
                    gap_nxt   = '0;
                end else begin
                    idx_nxt      = idx + 3'd1;
                    sr_out_nxt   = code_buf[idx + 3'd1];
                    sr_valid_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ST_COLLECT;
                    done_nxt  = 1'b1;
                    count_nxt = '0;
                    for (int i = 0; i < 8; i++)
                        buf_nxt[i] = '0;
                end else begin
                    gap_nxt = gap_cnt + 16'd1;
                end
            end
            default: state_nxt = ST_COLLECT;
        endcase

        busy_nxt = (state_nxt != ST_COLLECT);
    end
endmodule

// File: tb/tb_keypad_code_tx.sv
// Directed bench for keypad_code_tx with default parameters (CODE_LEN 4, DEBOUNCE 4, GAP 2).
module tb_keypad_code_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sw_in;
    logic       enter, clear, rx_ready;
    logic [9:0] sr_out;
    logic       sr_valid, busy, frame_done;
    logic [2:0] digit_count;

    int vectors = 0;
    int errors  = 0;

    keypad_code_tx dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .enter(enter), .clear(clear),
        .rx_ready(rx_ready), .sr_out(sr_out), .sr_valid(sr_valid), .busy(busy),
        .digit_count(digit_count), .frame_done(frame_done));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        sw_in    = '0;
        sw_in[k] = 1'b1;
        idle(12);
        sw_in = '0;
        idle(12);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sr_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic expect_frame(input string tag, input logic [9:0] a, input logic [9:0] b,
                                input logic [9:0] c, input logic [9:0] d);
        logic [9:0] e [4];
        bit ok;
        e = '{a, b, c, d};
        wait_valid(ok);
        chk({tag, "_start"}, 32'(ok), 32'd1);
        if (!ok) return;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_d%0d", tag, i), 32'(sr_out), 32'(e[i]));
            chk($sformatf("%s_v%0d", tag, i), 32'(sr_valid), 32'd1);
            @(negedge clk);
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_gap%0d", tag, g), 32'({sr_valid, sr_out, frame_done}), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(frame_done), 32'd1);
        chk({tag, "_cnt0"}, 32'(digit_count), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        bit ok;
        bit seen;
        rst = 1'b1; sw_in = '0; enter = 1'b0; clear = 1'b0; rx_ready = 1'b0;
        idle(3);
        chk("rst_sr_out", 32'(sr_out), 32'd0);
        chk("rst_sr_valid", 32'(sr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(digit_count), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        idle(2);

        // Full code 3,0,1,2
        press(3); press(0); press(1);
        chk("full_cnt3", 32'(digit_count), 32'd3);
        press(2);
        chk("full_cnt4", 32'(digit_count), 32'd4);
`ifdef KEYPAD_AUTO_SEND_EN
        chk("auto_armed", 32'(busy), 32'd1);
        rx_ready = 1'b1;
        expect_frame("full", 10'd8, 10'd1, 10'd2, 10'd4);
`else
        chk("no_auto_arm", 32'(busy), 32'd0);
        rx_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sr_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("no_send_before_enter", 32'(seen), 32'd0);
        enter = 1'b1;
        expect_frame("full", 10'd8, 10'd1, 10'd2, 10'd4);
        enter = 1'b0;
        idle(12);
`endif

        // Bounce on key 5
        rx_ready = 1'b0;
        sw_in = 10'd32; idle(1);
        sw_in = 10'd0;  idle(1);
        sw_in = 10'd32; idle(1);
        sw_in = 10'd0;  idle(1);
        sw_in = 10'd32; idle(12);
        sw_in = 10'd0;  idle(12);
        chk("bounce_cnt", 32'(digit_count), 32'd1);
        enter = 1'b1; rx_ready = 1'b1;
        expect_frame("bounce", 10'd32, 10'd0, 10'd0, 10'd0);
        enter = 1'b0;
        idle(12);

        // Chord, then clear in COLLECT
        sw_in = 10'b0000000110; idle(12);
        sw_in = '0; idle(12);
        chk("chord_cnt", 32'(digit_count), 32'd0);
        press(3);
        chk("pre_clear_cnt", 32'(digit_count), 32'd1);
        clear = 1'b1; idle(12);
        clear = 1'b0; idle(12);
        chk("clear_cnt", 32'(digit_count), 32'd0);
        chk("enter_empty_idle", 32'(busy), 32'd0);

`ifndef KEYPAD_AUTO_SEND_EN
        // Overflow: fifth press dropped
        for (int k = 1; k <= 5; k++) press(k);
        chk("overflow_cnt", 32'(digit_count), 32'd4);
        enter = 1'b1;
        expect_frame("overflow", 10'd2, 10'd4, 10'd8, 10'd16);
        enter = 1'b0;
        idle(12);
`endif

        // Short entry; clear while armed is discarded
        rx_ready = 1'b0;
        press(7);
        enter = 1'b1;
        wait_busy(ok);
        chk("short_armed", 32'(ok), 32'd1);
        clear = 1'b1;
        idle(15);
        chk("short_clear_ignored", 32'(digit_count), 32'd1);
        rx_ready = 1'b1;
        expect_frame("short", 10'd128, 10'd0, 10'd0, 10'd0);
        clear = 1'b0;
        enter = 1'b0;
        idle(12);

        // Handshake hold, then reset on second SEND cycle
        rx_ready = 1'b0;
        press(9); press(4);
        enter = 1'b1;
        wait_busy(ok);
        chk("hs_armed", 32'(ok), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b1 || sr_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk("hs_hold", 32'(seen), 32'd0);
        rx_ready = 1'b1;
        wait_valid(ok);
        chk("hs_start", 32'(ok), 32'd1);
        chk("hs_d0", 32'(sr_out), 32'd512);
        @(negedge clk);
        chk("hs_d1", 32'(sr_out), 32'd16);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'({sr_out, sr_valid, busy, frame_done, digit_count}), 32'd0);
        rst = 1'b0;
        enter = 1'b0;
        rx_ready = 1'b0;
        idle(12);
        press(6);
        chk("post_rst_collect", 32'(digit_count), 32'd1);
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
